// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and producer latency encodings for the register hazard scoreboard.
package hazard_scoreboard_pkg;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_REG_AW   = 5;
  localparam int DEF_LAT_W    = 2;
  localparam int DEF_CNT_W    = 16;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
endpackage

// File: rtl/hazard_sb_entry.sv
// Per-register countdown cell: cycles remaining until the pending result is forwardable.
module hazard_sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_W = DEF_LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  // A new producer overrides the countdown of an older one to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order decode hazard scoreboard: RAW/WAW stall detection against per-register latency counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int LAT_W    = DEF_LAT_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_rd_we,
  input  logic [LAT_W-1:0]    id_lat,
  input  logic                flush,
  output logic                stall,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic             raw_hz;
  logic             waw_hz;

  assign cnt[0]       = '0;
  assign busy_mask[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_entry
      hazard_sb_entry #(
        .LAT_W (LAT_W)
      ) u_entry (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (issue && id_rd_we && (id_rd == REG_AW'(r)) && (id_lat != LAT_W'(LAT_ALU))),
        .load_val (id_lat),
        .cnt      (cnt[r]),
        .busy     (busy_mask[r])
      );
    end
  endgenerate

  // Checks read the pre-update counters, so rs == rd sees the older producer.
  always_comb begin
    raw_hz = id_valid &&
             ((id_rs1_used && (id_rs1 != '0) && (cnt[id_rs1] != '0)) ||
              (id_rs2_used && (id_rs2 != '0) && (cnt[id_rs2] != '0)));
    waw_hz = id_valid && id_rd_we && (id_rd != '0) && (cnt[id_rd] > id_lat);
  end

  assign stall = (raw_hz || waw_hz) && !flush;
  assign issue = id_valid && !stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall)
      stall_cnt <= sat_inc(stall_cnt);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenario bench for hazard_scoreboard (CNT_W = 4 so saturation is reachable).
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int LW = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0;
  logic [AW-1:0] id_rs2 = '0;
  logic          id_rs1_used = 1'b0;
  logic          id_rs2_used = 1'b0;
  logic [AW-1:0] id_rd = '0;
  logic          id_rd_we = 1'b0;
  logic [LW-1:0] id_lat = '0;
  logic          flush = 1'b0;
  logic          stall;
  logic          issue;
  logic [NR-1:0] busy_mask;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad = 0;

  hazard_scoreboard #(
    .NUM_REGS (NR),
    .REG_AW   (AW),
    .LAT_W    (LW),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_rd_we    (id_rd_we),
    .id_lat      (id_lat),
    .flush       (flush),
    .stall       (stall),
    .issue       (issue),
    .busy_mask   (busy_mask),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input int rs1, input logic u1, input int rs2, input logic u2,
                       input int rd, input logic we, input int lat, input logic fl);
    id_valid = v; id_rs1 = AW'(rs1); id_rs1_used = u1; id_rs2 = AW'(rs2); id_rs2_used = u2;
    id_rd = AW'(rd); id_rd_we = we; id_lat = LW'(lat); flush = fl;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 5, 1'b1, 6, 1'b1, 5, 1'b1, 3, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL reset_issue: got %b want 1", issue); end
    tick();
    total++; if (busy_mask !== '0) begin bad++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL reset_scnt: got %0d want 0", stall_cnt); end
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_dependent();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, LAT_LOAD, 1'b0);
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL ld_prod_issue: got %b want 1", issue); end
    tick();
    drive(1'b1, 5, 1'b1, 0, 1'b0, 6, 1'b0, 0, 1'b0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL ld_dep_stall: got %b want 1", stall); end
    total++; if (issue !== 1'b0) begin bad++; $display("FAIL ld_dep_noissue: got %b want 0", issue); end
    total++; if (busy_mask[5] !== 1'b1) begin bad++; $display("FAIL ld_busy5: got %b want 1", busy_mask[5]); end
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld_dep_release: got %b want 0", stall); end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL ld_dep_issue: got %b want 1", issue); end
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL ld_scnt: got %0d want 1", stall_cnt); end
    tick();
    idle();
  endtask

  task automatic test_reg0_unused();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b0);
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL r0_issue: got %b want 1", issue); end
    tick();
    total++; if (busy_mask !== '0) begin bad++; $display("FAIL r0_busy: got %h want 0", busy_mask); end
    drive(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 3, 1'b0);
    tick();
    drive(1'b1, 0, 1'b1, 5, 1'b0, 0, 1'b0, 0, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_unused_rs2: got %b want 0", stall); end
    total++; if (busy_mask[5] !== 1'b1) begin bad++; $display("FAIL r0_busy5: got %b want 1", busy_mask[5]); end
    tick();
    drive(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b1, 3, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_src0: got %b want 0", stall); end
    tick();
    idle();
    tick();
    total++; if (busy_mask !== '0) begin bad++; $display("FAIL r0_drain: got %h want 0", busy_mask); end
  endtask

  task automatic test_waw();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 3, 1'b0);
    tick();
    idle();
    tick();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1, 1'b0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL waw_stall: got %b want 1", stall); end
    tick();
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL waw_issue: got %b want 1", issue); end
    tick();
    idle();
    total++; if (busy_mask[7] !== 1'b1) begin bad++; $display("FAIL waw_busy_hold: got %b want 1", busy_mask[7]); end
    tick();
    total++; if (busy_mask[7] !== 1'b0) begin bad++; $display("FAIL waw_busy_clear: got %b want 0", busy_mask[7]); end
    total++; if (stall_cnt !== 4'd2) begin bad++; $display("FAIL waw_scnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_flush();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 3, 1'b0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 9, 1'b1, 0, 1'b0, 10, 1'b1, 3, 1'b1);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_stall c%0d: got %b want 0", c, stall); end
      total++; if (issue !== 1'b0) begin bad++; $display("FAIL fl_issue c%0d: got %b want 0", c, issue); end
      total++; if (busy_mask[9] !== 1'b1) begin bad++; $display("FAIL fl_busy9 c%0d: got %b want 1", c, busy_mask[9]); end
      tick();
    end
    total++; if (busy_mask[9] !== 1'b0) begin bad++; $display("FAIL fl_drain9: got %b want 0", busy_mask[9]); end
    total++; if (busy_mask[10] !== 1'b0) begin bad++; $display("FAIL fl_noload10: got %b want 0", busy_mask[10]); end
    total++; if (stall_cnt !== 4'd2) begin bad++; $display("FAIL fl_scnt: got %0d want 2", stall_cnt); end
    idle();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 3, 1'b0);
    tick();
    idle();
    total++; if (busy_mask[3] !== 1'b1) begin bad++; $display("FAIL ar_busy3_pre: got %b want 1", busy_mask[3]); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (busy_mask !== '0) begin bad++; $display("FAIL ar_busy: got %h want 0", busy_mask); end
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL ar_scnt: got %0d want 0", stall_cnt); end
    rst_n = 1'b1;
    drive(1'b1, 3, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ar_nostall: got %b want 0", stall); end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL ar_issue: got %b want 1", issue); end
    tick();
    idle();
  endtask

  // Self-dependent load (rs1 = rd = 4, lat 3) holds for 28 cycles: 3 of every 4 stall.
  task automatic test_saturation();
    drive(1'b1, 4, 1'b1, 0, 1'b0, 4, 1'b1, 3, 1'b0);
    for (int c = 0; c < 8; c++) tick();
    total++; if (stall_cnt !== 4'd6) begin bad++; $display("FAIL sat_mid: got %0d want 6", stall_cnt); end
    for (int c = 8; c < 28; c++) tick();
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_full: got %0d want 15", stall_cnt); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL sat_phase: got %b want 0", stall); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_dependent();
    test_reg0_unused();
    test_waw();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
